// File: rtl/dc_fifo_pkg.sv
// Shared defaults for the dc_fifo elastic buffer.
// Holds only the default parameter values, so that every instantiation site
// starts from the same geometry unless it overrides it explicitly.
package dc_fifo_pkg;

    localparam int DC_FIFO_DATA_WIDTH_DEFAULT = 32;
    localparam int DC_FIFO_ADDR_WIDTH_DEFAULT = 2;

endpackage

// File: rtl/dc_fifo_mem.sv
// Storage array for dc_fifo: DEPTH x DATA_WIDTH registers.
// Ports:
//   clk    : clock
//   we     : write enable, writes wdata to mem[waddr] on the rising edge
//   waddr  : write address
//   wdata  : write data
//   re     : read enable, captures mem[raddr] into rdata on the rising edge
//   raddr  : read address
//   rdata  : registered read data, holds while re is low
// No reset: contents and rdata are undefined until written.
module dc_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata_reg <= mem_reg[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/dc_fifo.sv
// Single-clock FIFO used as a small elastic buffer (depth 2**ADDR_WIDTH).
// Ports:
//   clk      : single clock, all state updates on the rising edge
//   reset_n  : synchronous active-low reset
//   data_in  : write data, sampled when a write is accepted
//   wr_req   : write request, ignored while wr_full
//   wr_full  : FIFO holds DEPTH words
//   data_out : registered read data, 1 clk after an accepted read
//   rd_req   : read request, ignored while rd_empty
//   rd_empty : FIFO holds no words
module dc_fifo
    import dc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DC_FIFO_DATA_WIDTH_DEFAULT,
    parameter int ADDR_WIDTH = DC_FIFO_ADDR_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_req,
    output logic                  wr_full,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  rd_req,
    output logic                  rd_empty
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic                  out_zero_reg;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // The extra MSB distinguishes "full" from "empty" when the low bits match.
    assign rd_empty = (wr_ptr_reg == rd_ptr_reg);
    assign wr_full  = (wr_ptr_reg[ADDR_WIDTH-1:0] == rd_ptr_reg[ADDR_WIDTH-1:0]) &&
                      (wr_ptr_reg[PTR_W-1] != rd_ptr_reg[PTR_W-1]);

    // Flags come from the pre-edge pointers, so full+read frees a slot only
    // on the next cycle and empty+write has no bypass to the read side.
    assign wr_accept = wr_req && !wr_full;
    assign rd_accept = rd_req && !rd_empty;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            out_zero_reg <= 1'b1;
        end else begin
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (rd_accept) begin
                rd_ptr_reg   <= rd_ptr_reg + PTR_W'(1);
                out_zero_reg <= 1'b0;
            end
        end
    end

    // The storage read register has no reset; out_zero_reg masks it to zero
    // from reset until the first accepted read refreshes it.
    assign data_out = out_zero_reg ? '0 : mem_rdata;

    dc_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .we   (wr_accept && reset_n),
        .waddr(wr_ptr_reg[ADDR_WIDTH-1:0]),
        .wdata(data_in),
        .re   (rd_accept && reset_n),
        .raddr(rd_ptr_reg[ADDR_WIDTH-1:0]),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_dc_fifo.sv
module tb_dc_fifo;

    localparam int DW    = 32;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] data_in;
    logic          wr_req;
    logic          rd_req;
    logic          wr_full;
    logic          rd_empty;
    logic [DW-1:0] data_out;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: a queue of stored words and the last popped word.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] model_out;
    bit            model_valid = 0;

    always #5 clk = ~clk;

    dc_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .data_in (data_in),
        .wr_req  (wr_req),
        .wr_full (wr_full),
        .data_out(data_out),
        .rd_req  (rd_req),
        .rd_empty(rd_empty)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each rising edge, from the occupancy before the edge.
    always @(posedge clk) begin
        if (!reset_n) begin
            model_q.delete();
            model_out   = '0;
            model_valid = 1;
        end else if (model_valid) begin
            bit was_full;
            bit was_empty;
            was_full  = (model_q.size() == DEPTH);
            was_empty = (model_q.size() == 0);
            if (rd_req && !was_empty) model_out = model_q.pop_front();
            if (wr_req && !was_full) model_q.push_back(data_in);
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            check("rd_empty", DW'(rd_empty), DW'(model_q.size() == 0));
            check("wr_full",  DW'(wr_full),  DW'(model_q.size() == DEPTH));
            check("data_out", data_out, model_out);
        end
    end

    // Drive one cycle of inputs; returns at the next falling edge, when the
    // effect of the intervening rising edge is visible.
    task automatic step(input bit rst, input bit wr, input bit rd, input logic [DW-1:0] d);
        reset_n = !rst;
        wr_req  = wr;
        rd_req  = rd;
        data_in = d;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        data_in = '0;
        @(negedge clk);

        // Reset
        step(1, 1, 1, 32'h55);
        $display("txn reset");
        check("reset_empty", DW'(rd_empty), 1);
        check("reset_full",  DW'(wr_full), 0);
        check("reset_dout",  data_out, 0);

        // Fill
        step(0, 1, 0, 32'hAA);
        $display("txn write AA");
        check("fill1_empty", DW'(rd_empty), 0);
        check("fill1_full",  DW'(wr_full), 0);
        step(0, 1, 0, 32'hBB); $display("txn write BB");
        step(0, 1, 0, 32'hCC); $display("txn write CC");
        check("fill3_full",  DW'(wr_full), 0);
        step(0, 1, 0, 32'hDD); $display("txn write DD");
        check("fill4_full",  DW'(wr_full), 1);

        // Overflow
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 32'hEE);
            $display("txn write EE while full");
            check("ovf_full", DW'(wr_full), 1);
        end

        // Drain
        step(0, 1'b0, 1, 0); $display("txn read -> %h", data_out); check("drain_aa", data_out, 32'hAA);
        step(0, 1'b0, 1, 0); $display("txn read -> %h", data_out); check("drain_bb", data_out, 32'hBB);
        step(0, 1'b0, 1, 0); $display("txn read -> %h", data_out); check("drain_cc", data_out, 32'hCC);
        check("drain3_empty", DW'(rd_empty), 0);
        step(0, 1'b0, 1, 0); $display("txn read -> %h", data_out); check("drain_dd", data_out, 32'hDD);
        check("drain4_empty", DW'(rd_empty), 1);
        step(0, 1'b0, 1, 0); $display("txn read while empty -> %h", data_out);
        check("drain_hold", data_out, 32'hDD);

        // Simultaneous with 2 stored, crossing the pointer wrap
        step(0, 1, 0, 32'h1); $display("txn write 1");
        step(0, 1, 0, 32'h2); $display("txn write 2");
        for (int i = 0; i < 4; i++) begin
            logic [DW-1:0] wv;
            wv = DW'(i + 3);
            step(0, 1, 1, wv);
            $display("txn write %h + read -> %h", wv, data_out);
            check("simul_dout", data_out, DW'(i + 1));
            check("simul_empty", DW'(rd_empty), 0);
            check("simul_full",  DW'(wr_full), 0);
        end
        step(0, 1, 0, 32'h7); $display("txn write 7");
        step(0, 1, 0, 32'h8); $display("txn write 8");
        check("refill_full", DW'(wr_full), 1);
        step(0, 1, 1, 32'h9); $display("txn write 9 + read from full -> %h", data_out);
        check("full_rw_dout", data_out, 32'h5);
        check("full_rw_full", DW'(wr_full), 0);
        step(0, 1'b0, 1, 0); check("full_rw_next", data_out, 32'h6);
        $display("txn read -> %h", data_out);

        // Mid-operation reset with 3 stored (6 gone: 7,8 left) -> add one more
        step(0, 1, 0, 32'hA); $display("txn write A");
        step(1, 0, 0, 0); $display("txn mid-op reset");
        check("mid_rst_empty", DW'(rd_empty), 1);
        check("mid_rst_dout",  data_out, 0);
        step(0, 1'b0, 1, 0); $display("txn read while empty -> %h", data_out);
        check("mid_rst_noread", data_out, 0);
        step(0, 1, 0, 32'h11); $display("txn write 11");
        step(0, 1'b0, 1, 0); $display("txn read -> %h", data_out);
        check("mid_rst_11", data_out, 32'h11);

        // Empty + write + read: only the write occurs
        step(0, 1, 1, 32'h22); $display("txn write 22 + read while empty -> %h", data_out);
        check("empty_rw_dout", data_out, 32'h11);
        check("empty_rw_empty", DW'(rd_empty), 0);

        // Randomized phase, checked by the per-cycle compare process
        for (int i = 0; i < 2000; i++) begin
            bit rst;
            bit wr;
            bit rd;
            logic [DW-1:0] d;
            rst = ($urandom_range(63) == 0);
            wr  = ($urandom_range(99) < 55);
            rd  = ($urandom_range(99) < 50);
            d   = $urandom;
            step(rst, wr, rd, d);
            $display("txn rand rst=%0d wr=%0d rd=%0d din=%h dout=%h empty=%0d full=%0d",
                     rst, wr, rd, d, data_out, rd_empty, wr_full);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
